// File: rtl/mac_requant_pkg.sv
// Shared types, default widths and output saturation limits for the mac_requant block.
package mac_requant_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   localparam int DEF_IN_WIDTH   = 38;
   localparam int DEF_PASS_BITS  = 6;
   localparam int DEF_OUT_WIDTH  = 16;
   localparam int DEF_FIFO_DEPTH = 4;

   function automatic longint sat_hi(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_lo(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/requant_fifo.sv
// Synchronous output buffer with occupancy count; head word reads as zero while empty.
module requant_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     arst_n_in,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == FULL_C);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mac_requant.sv
// mac_requant: accumulates multi-pass partial sums, then rounds, shifts and saturates into an output FIFO.
// Build macro MAC_REQUANT_RELU_EN clamps negative results to zero ahead of saturation.
module mac_requant
   import mac_requant_pkg::*;
#(
   parameter int IN_WIDTH   = DEF_IN_WIDTH,
   parameter int PSUM_WIDTH = IN_WIDTH + DEF_PASS_BITS,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  arst_n_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_last,
   input  logic [PSUM_WIDTH-1:0] bias,
   input  logic [5:0]            shift_amt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  sat_flag,
   output logic                  pass_err,
   input  logic                  clr_flags
);
   localparam int RW = PSUM_WIDTH + 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam longint SAT_HI_L = sat_hi(OUT_WIDTH);
   localparam longint SAT_LO_L = sat_lo(OUT_WIDTH);
   localparam logic signed [RW-1:0] SAT_HI = SAT_HI_L[RW-1:0];
   localparam logic signed [RW-1:0] SAT_LO = SAT_LO_L[RW-1:0];
   localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

   function automatic logic signed [RW-1:0] round_shift(input logic signed [PSUM_WIDTH-1:0] v,
                                                        input logic [5:0] sh);
      logic signed [RW-1:0] ext;
      logic [RW-1:0]        half;
      ext  = {v[PSUM_WIDTH-1], v};
      half = '0;
      if (sh != 6'd0) half = {{(RW-1){1'b0}}, 1'b1} << (sh - 6'd1);
      return (ext + $signed(half)) >>> sh;
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [RW-1:0] v);
      if (v > SAT_HI) return SAT_HI[OUT_WIDTH-1:0];
      if (v < SAT_LO) return SAT_LO[OUT_WIDTH-1:0];
      return v[OUT_WIDTH-1:0];
   endfunction

   function automatic logic clamps(input logic signed [RW-1:0] v);
      return (v > SAT_HI) || (v < SAT_LO);
   endfunction

   state_t                        state_q, state_d;
   logic signed [PSUM_WIDTH-1:0]  psum_q, psum_d;
   logic signed [PSUM_WIDTH-1:0]  in_ext, base, sum;
   logic [5:0]                    cnt_q, cnt_d;
   logic                          accept, emit, force_last;
   logic signed [PSUM_WIDTH-1:0]  sum_p0;
   logic                          vld_p0;
   logic signed [RW-1:0]          shifted, relu;
   logic signed [OUT_WIDTH-1:0]   q_data;
   logic                          q_clamped;
   logic [CW-1:0]                 fifo_count;
   logic                          fifo_empty;
   logic [CW:0]                   occ;

   // Room is reserved for the value sitting in the requant stage so nothing is ever dropped.
   assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p0};
   assign in_ready = arst_n_in && (occ < DEPTH_C);
   assign accept   = in_valid && in_ready;

   assign in_ext = {{(PSUM_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
   assign base   = (state_q == IDLE) ? bias : psum_q;
   assign sum    = base + in_ext;

   always_comb begin
      state_d    = state_q;
      psum_d     = psum_q;
      cnt_d      = cnt_q;
      emit       = 1'b0;
      force_last = 1'b0;
      if (accept) begin
         force_last = !in_last && (cnt_q == 6'd63);
         emit       = in_last || force_last;
         if (emit) begin
            state_d = IDLE;
            psum_d  = '0;
            cnt_d   = '0;
         end else begin
            state_d = ACCUM;
            psum_d  = sum;
            cnt_d   = cnt_q + 6'd1;
         end
      end
   end

   // p0: accumulator and emitted-sum register
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q <= IDLE;
         psum_q  <= '0;
         cnt_q   <= '0;
         sum_p0  <= '0;
         vld_p0  <= 1'b0;
      end else begin
         state_q <= state_d;
         psum_q  <= psum_d;
         cnt_q   <= cnt_d;
         vld_p0  <= emit;
         if (emit) sum_p0 <= sum;
      end
   end

   // p1: round, shift, optional ReLU, saturate, then push into the FIFO
   always_comb begin
      shifted = round_shift(sum_p0, shift_amt);
`ifdef MAC_REQUANT_RELU_EN
      relu = shifted[RW-1] ? '0 : shifted;
`else
      relu = shifted;
`endif
      q_data    = saturate(relu);
      q_clamped = clamps(relu);
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         sat_flag <= 1'b0;
         pass_err <= 1'b0;
      end else begin
         if (clr_flags)            sat_flag <= 1'b0;
         if (vld_p0 && q_clamped)  sat_flag <= 1'b1;
         if (clr_flags)            pass_err <= 1'b0;
         if (force_last)           pass_err <= 1'b1;
      end
   end

   requant_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .push      (vld_p0),
      .push_data (q_data),
      .pop       (out_ready),
      .pop_data  (out_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign out_valid = !fifo_empty;

endmodule
